// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU into HI/LO, plus MTHI/MTLO writes.
// Latency 33 cycles start-to-done; no backpressure, start and HI/LO writes are dropped while busy.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] work;
  logic [31:0] opnd;
  logic [31:0] a_lat;
  logic        is_div, neg_q, neg_r, div_zero;

  logic        launch, step, finish, mt_hi, mt_lo;

  logic        sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [63:0] mul_next, div_next, prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // State register; busy is registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cnt == 5'd31) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    launch = (state == S_IDLE) && start;
    step   = (state == S_RUN);
    finish = (state == S_FIX);
    mt_hi  = (state == S_IDLE) && !start && wr_hi;
    mt_lo  = (state == S_IDLE) && !start && wr_lo;
  end

  always_comb begin
    sgn   = ~op[0];
    a_neg = sgn & a[31];
    b_neg = sgn & b[31];
    a_mag = a_neg ? (32'd0 - a) : a;
    b_mag = b_neg ? (32'd0 - b) : b;

    // Multiply: work = {partial product, remaining multiplier bits}.
    mul_sum  = {1'b0, work[63:32]} + {1'b0, (work[0] ? opnd : 32'd0)};
    mul_next = {mul_sum, work[31:1]};

    // Divide: work = {remainder, dividend bits becoming quotient bits}.
    div_shift = {work[63:32], work[31]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[31:0] - opnd;
    div_next  = div_ge ? {div_diff, work[30:0], 1'b1}
                       : {div_shift[31:0], work[30:0], 1'b0};

    prod_fix = neg_q ? (64'd0 - work) : work;
    quo_fix  = neg_q ? (32'd0 - work[31:0]) : work[31:0];
    rem_fix  = neg_r ? (32'd0 - work[63:32]) : work[63:32];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= 5'd0;
      work     <= 64'd0;
      opnd     <= 32'd0;
      a_lat    <= 32'd0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      done     <= 1'b0;
    end else begin
      done <= finish;
      if (launch) begin
        cnt      <= 5'd0;
        is_div   <= op[1];
        neg_q    <= a_neg ^ b_neg;
        neg_r    <= a_neg;
        div_zero <= op[1] && (b == 32'd0);
        a_lat    <= a;
        opnd     <= op[1] ? b_mag : a_mag;
        work     <= {32'd0, (op[1] ? a_mag : b_mag)};
      end
      if (step) begin
        cnt  <= cnt + 5'd1;
        work <= is_div ? div_next : mul_next;
      end
      if (finish) begin
        if (!is_div) begin
          hi <= prod_fix[63:32];
          lo <= prod_fix[31:0];
        end else if (div_zero) begin
          hi <= a_lat;
          lo <= 32'hFFFF_FFFF;
        end else begin
          hi <= rem_fix;
          lo <= quo_fix;
        end
      end
      if (mt_hi) hi <= wr_data;
      if (mt_lo) lo <= wr_data;
    end
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit in the EX stage, alongside the single-cycle ALU. It executes MULT, MULTU, DIV and DIVU into the architectural HI/LO registers, and takes MTHI/MTLO writes. It exposes a start/busy/done handshake so hazard control can stall MFHI/MFLO and back-to-back mult/div until the result lands. Operands arrive from the same forwarded rs/rt buses that feed the ALU.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  launch operation; sampled only while idle
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  32  rs operand (multiplicand / dividend)
- b  in  32  rt operand (multiplier / divisor)
- wr_hi  in  1  MTHI write enable
- wr_lo  in  1  MTLO write enable
- wr_data  in  32  MTHI/MTLO data
- busy  out  1  operation in flight; stall consumers of HI/LO
- done  out  1  one-cycle pulse: HI/LO just updated by mult/div
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1:
  - latch op, a, b;
  - for signed ops, latch |a|, |b| and the result-sign flags;
  - go to RUN; iteration counter = 0.
- RUN: one radix-2 step per cycle, 32 steps, counter 0..31.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, yielding a 32-bit quotient and remainder.
  - Counter == 31 -> FIX.
- FIX:
  - apply sign correction;
  - write HI/LO, pulse done, return to IDLE.
- Result mapping:
  - Multiply: HI = product[63:32], LO = product[31:0]. Signed product is negated when exactly one operand is negative.
  - Divide: LO = quotient, HI = remainder. Signed quotient is negated when the operand signs differ; signed remainder takes the sign of the dividend.
- Arithmetic wraps mod 2^32 per register. DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- Divide by zero (b == 0):
  - no trap, full latency;
  - HI = a as latched, LO = 0xFFFFFFFF, for both DIV and DIVU.
- Operand inputs are ignored after the start edge; later changes to a/b do not affect the result.
- start while busy: ignored, no queuing. Hazard control must not issue it.
- wr_hi/wr_lo:
  - applied only in IDLE; HI/LO update on the next edge;
  - both may be asserted together, writing the same data to both;
  - ignored while busy.
- start and wr_hi/wr_lo in the same IDLE cycle: start wins, write dropped.

## Timing
- Reset (asynchronous, any state): state = IDLE, busy = 0, done = 0, hi = 0, lo = 0, counter = 0. An in-flight operation is abandoned and never produces done.
- Start edge E0 (start=1 in IDLE): busy = 1 from after E0.
- Edges E1..E32 perform the 32 RUN steps.
- E33 is the FIX edge:
  - hi/lo take final values;
  - done = 1 for exactly the following cycle;
  - busy = 0 from the following cycle.
- Total latency: done and valid hi/lo visible 33 cycles after the start edge. busy is high for 33 cycles.
- New start is accepted in the same cycle done is high, because the unit is IDLE then.
- hi/lo never change mid-operation; intermediate state is internal only.
- MTHI/MTLO result is visible one cycle after the write cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 cycles done=1, HI=0xFFFFFFFE, LO=0x00000001; busy high exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=7, b=0 -> HI=7, LO=0xFFFFFFFF.
- Control scenarios:
  - start MULTU 6*7;
  - assert reset at cycle 10 -> busy=0, HI=LO=0, no done;
  - restart -> HI=0, LO=42;
  - during busy, pulse start (different op) and wr_hi -> both ignored;
  - then in IDLE, wr_lo with wr_data=0x12345678 -> LO=0x12345678 next cycle.
